iomem_gpio: RTL and testbench
=============================

# iomem_gpio

Parametrised memory-mapped GPIO peripheral on the picosoc `iomem` bus, replacing the fixed 32-bit output-only register at page 0x03. Adds per-pin direction control, synchronised inputs, atomic set/clear/toggle, and per-pin rising/falling edge interrupts with write-1-to-clear status. Sits in the SoC top beside the other `iomem` decoders; its `irq` output drives one of `irq_5..irq_7`.

## Interface
Parameters:
- `WIDTH`, 32: number of GPIO pins, 1..32; register bits at and above `WIDTH` read 0 and ignore writes.
- `BASE_PAGE`, 8'h03: value of `iomem_addr[31:24]` that selects this block.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.
- `OUT_RESET`, 0: reset value of DATA_OUT, `WIDTH` bits.

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: synchronous, active-low reset, sampled on rising `clk`.
- `iomem_valid` in 1: bus request.
- `iomem_ready` out 1: one-cycle access acknowledge.
- `iomem_wstrb` in 4: byte write strobes; 0 = read.
- `iomem_addr` in 32: byte address; `[31:24]` page select, `[7:2]` register offset.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while `iomem_ready` = 1.
- `gpio_in` in `WIDTH`: asynchronous pin inputs.
- `gpio_out` out `WIDTH`: output values (= DATA_OUT).
- `gpio_oe` out `WIDTH`: output enables (= DIR, 1 = drive).
- `irq` out 1: level interrupt, `|(IRQ_STATUS & (IRQ_RISE_EN | IRQ_FALL_EN))`.

## Operation
- Register map (offset = `iomem_addr[7:0]`): 0x00 DATA_OUT rw; 0x04 DIR rw; 0x08 DATA_IN ro (synchronised pins); 0x0C SET wo (DATA_OUT |= wdata); 0x10 CLR wo (DATA_OUT &= ~wdata); 0x14 TGL wo (DATA_OUT ^= wdata); 0x18 IRQ_RISE_EN rw; 0x1C IRQ_FALL_EN rw; 0x20 IRQ_STATUS rw1c.
- `iomem_addr[23:8]` ignored (registers alias across the page). Offsets 0x24..0xFC: acknowledged, read 0, writes ignored. Write-only registers read 0.
- All writes honour byte strobes: strobe byte n gates bits `[8n+7:8n]` of the effect (including SET/CLR/TGL/W1C).
- Mixed strobe (read+write) not distinguished: any nonzero `iomem_wstrb` is a write; `iomem_rdata` still returns the register's pre-write value.
- Input path: `SYNC_STAGES` flops per pin → DATA_IN; one further flop `prev` holds the last DATA_IN. rise = DATA_IN & ~prev, fall = ~DATA_IN & prev.
- IRQ_STATUS bit i sets on (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]); clears only by writing 1. Set in the same cycle as a W1C of that bit: set wins (status stays 1).
- Disabling an enable does not clear pending status; `irq` drops because the masked OR goes to 0, and re-asserts if re-enabled while status still set.
- Inputs are sampled regardless of DIR (output pins read back their pad).

## Timing
- Access: block decodes `iomem_valid & !iomem_ready & iomem_addr[31:24]==BASE_PAGE`; on that edge it registers `iomem_ready`=1, `iomem_rdata`, and applies the write. `iomem_ready` is high exactly one cycle, then 0; back-to-back accesses therefore take ≥2 cycles each. Not selected → `iomem_ready` stays 0, `iomem_rdata` holds.
- `gpio_out`/`gpio_oe` change in the cycle `iomem_ready` is high.
- Pin change stable before edge E0 → DATA_IN reflects it after edge E0+SYNC_STAGES-1; IRQ_STATUS and `irq` after edge E0+SYNC_STAGES.
- Reset (`resetn`=0 at an edge, including mid-access): DATA_OUT=OUT_RESET, DIR=0, all IRQ enables and status=0, sync flops and `prev`=0, `iomem_ready`=0, `iomem_rdata`=0, `irq`=0. An access in flight is dropped; the master retries after reset. First cycle out of reset: an input already high produces a rise, but enables are 0, so no status sets.

## Test plan
- Reset/readback: after reset read 0x00 → OUT_RESET, 0x04 → 0, `irq`=0; write 0x00=0xA5A5A5A5 strobe 4'b0011 → read 0x00 = 0x0000A5A5 (OUT_RESET=0), `gpio_out` matches same cycle as `iomem_ready`.
- Atomics: DATA_OUT=0x0F0F0F0F; SET 0xF0000000 → 0xFF0F0F0F; CLR 0x0000000F → 0xFF0F0F00; TGL 0xFFFFFFFF → 0x00F0F0FF; each write acked with a one-cycle `iomem_ready`.
- Edge IRQ: RISE_EN=0x1, FALL_EN=0x2; raise `gpio_in[0]` → `irq`=1 after SYNC_STAGES+1 edges, STATUS=0x1; write STATUS=0x1 → `irq`=0; drop `gpio_in[1]` from 1 → STATUS=0x2; rising on pin 1 → no status.
- Set-wins race: align pin-0 rise so status set coincides with W1C of bit 0 → STATUS bit 0 remains 1, `irq` stays 1.
- WIDTH=8, BASE_PAGE=8'h05: write 0x00=0xFFFFFFFF → read 0xFF; access at page 0x03 → no `iomem_ready`; offset 0x40 → ready, rdata 0.
- Reset mid-access: assert `resetn`=0 on the edge after `iomem_valid` rises → `iomem_ready` never asserts, registers at reset values.

Source files
------------

// File: rtl/iomem_gpio.sv
// iomem_gpio: picosoc iomem GPIO with direction, synchronised inputs, atomic set/clr/tgl, edge interrupts
module iomem_gpio #(
  parameter int WIDTH = 32,
  parameter logic [7:0] BASE_PAGE = 8'h03,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  logic [WIDTH-1:0] dir, ren, fen, st, prev, din, mask, wd, ev, nxt_out;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [31:0] bmask, rd;
  logic [5:0] off;
  logic sel, wr, unused_addr;
  assign sel = iomem_valid & ~iomem_ready & (iomem_addr[31:24] == BASE_PAGE);
  assign wr = sel & |iomem_wstrb;
  assign off = iomem_addr[7:2];
  assign unused_addr = ^{iomem_addr[23:8], iomem_addr[1:0]};
  assign bmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign mask = bmask[WIDTH-1:0];
  assign wd = iomem_wdata[WIDTH-1:0] & mask;
  assign din = sync_q[SYNC_STAGES-1];
  assign ev = (din & ~prev & ren) | (~din & prev & fen);
  assign gpio_oe = dir;
  assign irq = |(st & (ren | fen));
  always_comb begin
    nxt_out = off == 6'd0 ? (gpio_out & ~mask) | wd :
              off == 6'd3 ? gpio_out | wd :
              off == 6'd4 ? gpio_out & ~wd :
              off == 6'd5 ? gpio_out ^ wd : gpio_out;
  end
  always_comb begin
    rd = '0;
    case (off)
      6'd0: rd[WIDTH-1:0] = gpio_out;
      6'd1: rd[WIDTH-1:0] = dir;
      6'd2: rd[WIDTH-1:0] = din;
      6'd6: rd[WIDTH-1:0] = ren;
      6'd7: rd[WIDTH-1:0] = fen;
      6'd8: rd[WIDTH-1:0] = st;
      default: rd = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      gpio_out <= OUT_RESET;
      dir <= '0;
      ren <= '0;
      fen <= '0;
      st <= '0;
      prev <= '0;
      sync_q <= '{default: '0};
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= din;
      iomem_ready <= sel;
      if (sel) iomem_rdata <= rd;
      if (wr) begin
        gpio_out <= nxt_out;
        if (off == 6'd1) dir <= (dir & ~mask) | wd;
        if (off == 6'd6) ren <= (ren & ~mask) | wd;
        if (off == 6'd7) fen <= (fen & ~mask) | wd;
      end
      // a new edge event wins over a simultaneous write-1-to-clear
      st <= (st & ~((wr && off == 6'd8) ? wd : '0)) | ev;
    end
  end
endmodule

// File: tb/tb_iomem_gpio.sv
// tb_iomem_gpio: randomized and directed checks of iomem_gpio against a register-level model
module tb_iomem_gpio;
  localparam int S = 3;
  logic clk = 0, resetn = 0, valid = 0;
  logic [3:0] wstrb = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic ready0, ready1, irq0, irq1;
  logic [31:0] rdata0, rdata1, gpio_in0 = 0, gpio_out0, gpio_oe0;
  logic [7:0] gpio_in1 = 0, gpio_out1, gpio_oe1;
  int total = 0, bad = 0;
  logic [31:0] m_out = 0, m_dir = 0, m_ren = 0, m_fen = 0, m_st = 0, m_pins = 0;
  logic [31:0] rd;
  bit ok;

  always #5 clk = ~clk;

  iomem_gpio #(.WIDTH(32), .BASE_PAGE(8'h03), .SYNC_STAGES(S)) dut0 (
    .clk(clk), .resetn(resetn), .iomem_valid(valid), .iomem_ready(ready0), .iomem_wstrb(wstrb),
    .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata0), .gpio_in(gpio_in0),
    .gpio_out(gpio_out0), .gpio_oe(gpio_oe0), .irq(irq0));

  iomem_gpio #(.WIDTH(8), .BASE_PAGE(8'h05)) dut1 (
    .clk(clk), .resetn(resetn), .iomem_valid(valid), .iomem_ready(ready1), .iomem_wstrb(wstrb),
    .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata1), .gpio_in(gpio_in1),
    .gpio_out(gpio_out1), .gpio_oe(gpio_oe1), .irq(irq1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] off);
    case (off)
      8'h00: return m_out;
      8'h04: return m_dir;
      8'h08: return m_pins;
      8'h18: return m_ren;
      8'h1C: return m_fen;
      8'h20: return m_st;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_irq();
    return |(m_st & (m_ren | m_fen));
  endfunction

  task automatic m_write(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] mk, w;
    mk = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    w = d & mk;
    case (off)
      8'h00: m_out = (m_out & ~mk) | w;
      8'h04: m_dir = (m_dir & ~mk) | w;
      8'h0C: m_out = m_out | w;
      8'h10: m_out = m_out & ~w;
      8'h14: m_out = m_out ^ w;
      8'h18: m_ren = (m_ren & ~mk) | w;
      8'h1C: m_fen = (m_fen & ~mk) | w;
      8'h20: m_st = m_st & ~w;
      default: ;
    endcase
  endtask

  // drives one access and waits a bounded number of edges for the selected instance's ack
  task automatic bus(input int inst, input logic [7:0] page, input logic [7:0] off,
                     input logic [3:0] s, input logic [31:0] d, output logic [31:0] r, output bit got);
    valid = 1; addr = {page, 16'($urandom), off}; wstrb = s; wdata = d;
    got = 0; r = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (inst == 0 ? ready0 : ready1) begin
        got = 1;
        r = inst == 0 ? rdata0 : rdata1;
      end
    end
    valid = 0; wstrb = 0;
  endtask

  task automatic acc(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] r;
    bit g;
    bus(0, 8'h03, off, s, d, r, g);
    check($sformatf("ack@%h", off), 32'(g), 1);
    check($sformatf("rd@%h", off), r, m_read(off));
    m_write(off, s, d);
    check($sformatf("gpio_out@%h", off), gpio_out0, m_out);
    check($sformatf("gpio_oe@%h", off), gpio_oe0, m_dir);
    check($sformatf("irq@%h", off), 32'(irq0), 32'(m_irq()));
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(ready0), 0);
  endtask

  task automatic set_pins(input logic [31:0] v);
    logic [31:0] old;
    old = m_pins;
    gpio_in0 = v;
    repeat (S + 2) @(posedge clk);
    #1;
    m_st = m_st | (v & ~old & m_ren) | (~v & old & m_fen);
    m_pins = v;
    check("irq_pins", 32'(irq0), 32'(m_irq()));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    check("rst_ready", 32'(ready0), 0);
    check("rst_irq", 32'(irq0), 0);
    check("rst_out", gpio_out0, 0);
    check("rst_oe", gpio_oe0, 0);
    acc(8'h00, 4'h0, 0);
    acc(8'h04, 4'h0, 0);
    acc(8'h00, 4'b0011, 32'hA5A5A5A5);
    check("strobe_out", gpio_out0, 32'h0000A5A5);
    acc(8'h00, 4'h0, 0);
    // atomics
    acc(8'h00, 4'hF, 32'h0F0F0F0F);
    acc(8'h0C, 4'hF, 32'hF0000000);
    check("set", gpio_out0, 32'hFF0F0F0F);
    acc(8'h10, 4'hF, 32'h0000000F);
    check("clr", gpio_out0, 32'hFF0F0F00);
    acc(8'h14, 4'hF, 32'hFFFFFFFF);
    check("tgl", gpio_out0, 32'h00F0F0FF);
    acc(8'h0C, 4'h0, 0);
    // edge interrupts
    acc(8'h18, 4'hF, 32'h1);
    acc(8'h1C, 4'hF, 32'h2);
    set_pins(32'h2);
    gpio_in0 = 32'h3;
    for (int i = 1; i <= S + 1; i++) begin
      @(posedge clk); #1;
      check($sformatf("irq_lat%0d", i), 32'(irq0), 32'(i == S + 1));
    end
    m_st = m_st | 32'h1; m_pins = 32'h3;
    acc(8'h20, 4'h0, 0);
    acc(8'h08, 4'h0, 0);
    acc(8'h20, 4'hF, 32'h1);
    check("w1c_irq", 32'(irq0), 0);
    set_pins(32'h1);
    acc(8'h20, 4'h0, 0);
    check("fall_irq", 32'(irq0), 1);
    set_pins(32'h3);
    acc(8'h20, 4'h0, 0);
    // set-wins race on bit 0
    acc(8'h20, 4'hF, 32'h2);
    set_pins(32'h2);
    gpio_in0 = 32'h3;
    repeat (S) @(posedge clk);
    #1;
    bus(0, 8'h03, 8'h20, 4'hF, 32'h1, rd, ok);
    check("race_ack", 32'(ok), 1);
    check("race_rd", rd, 0);
    m_st = m_st | 32'h1; m_pins = 32'h3;
    @(posedge clk); #1;
    check("race_irq", 32'(irq0), 1);
    acc(8'h20, 4'h0, 0);
    // disabling keeps pending status, re-enabling re-raises irq
    acc(8'h18, 4'hF, 0);
    acc(8'h18, 4'hF, 32'h1);
    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) set_pins($urandom);
      else begin
        int k;
        logic [7:0] off;
        k = $urandom_range(0, 11);
        off = k < 9 ? 8'(k * 4) : {6'($urandom_range(9, 63)), 2'b00};
        acc(off, $urandom_range(0, 3) == 0 ? 4'h0 : 4'($urandom), $urandom);
      end
    end
    // narrow instance on page 5
    bus(1, 8'h05, 8'h00, 4'hF, 32'hFFFFFFFF, rd, ok);
    check("w8_ack", 32'(ok), 1);
    check("w8_out", 32'(gpio_out1), 32'hFF);
    @(posedge clk); #1;
    bus(1, 8'h05, 8'h00, 4'h0, 0, rd, ok);
    check("w8_rd", rd, 32'hFF);
    @(posedge clk); #1;
    bus(1, 8'h03, 8'h00, 4'h0, 0, rd, ok);
    check("w8_wrong_page", 32'(ok), 0);
    @(posedge clk); #1;
    bus(1, 8'h05, 8'h40, 4'hF, 32'h12345678, rd, ok);
    check("w8_hole_ack", 32'(ok), 1);
    check("w8_hole_rd", rd, 0);
    @(posedge clk); #1;
    // reset lands on the edge that would have acked
    valid = 1; addr = 32'h03000000; wstrb = 4'hF; wdata = 32'hFFFFFFFF; resetn = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_mid_ready%0d", i), 32'(ready0), 0);
    end
    valid = 0; wstrb = 0; resetn = 1;
    m_out = 0; m_dir = 0; m_ren = 0; m_fen = 0; m_st = 0;
    repeat (S + 2) @(posedge clk);
    #1;
    m_pins = gpio_in0;
    check("rst_mid_irq", 32'(irq0), 0);
    acc(8'h00, 4'h0, 0);
    acc(8'h04, 4'h0, 0);
    acc(8'h20, 4'h0, 0);
    acc(8'h08, 4'h0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
